jtag_tap_ctrl: RTL

JTAG_TAP_CTRL -- requirements
Module: jtag_tap_ctrl

---
 rtl/jtag_tap_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/jtag_tap_ctrl.sv
// IEEE 1149.1 TAP controller with IDCODE, BYPASS and one user data register.
// The TAP runs in the system clock domain; tck_en marks each TCK rising edge.
module jtag_tap_ctrl #(
  parameter int                  IR_WIDTH   = 4,
  parameter int                  DR_WIDTH   = 32,
  parameter logic [31:0]         IDCODE_VAL = 32'h1000_0001,
  parameter logic [IR_WIDTH-1:0] IDCODE_IR  = IR_WIDTH'(4'h1),
  parameter logic [IR_WIDTH-1:0] USER_IR    = IR_WIDTH'(4'h8)
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                tck_en,
  input  logic                tms,
  input  logic                tdi,
  output logic                tdo,
  output logic                tdo_en,
  output logic [3:0]          tap_state,
  output logic [IR_WIDTH-1:0] ir_out,
  input  logic [DR_WIDTH-1:0] user_cap_data,
  output logic [DR_WIDTH-1:0] user_upd_data,
  output logic                user_upd_valid
);

  typedef enum logic [3:0] {
    TLR      = 4'd0,  RTI      = 4'd1,  SEL_DR   = 4'd2,  CAP_DR   = 4'd3,
    SHIFT_DR = 4'd4,  EXIT1_DR = 4'd5,  PAUSE_DR = 4'd6,  EXIT2_DR = 4'd7,
    UPD_DR   = 4'd8,  SEL_IR   = 4'd9,  CAP_IR   = 4'd10, SHIFT_IR = 4'd11,
    EXIT1_IR = 4'd12, PAUSE_IR = 4'd13, EXIT2_IR = 4'd14, UPD_IR   = 4'd15
  } tap_state_e;

  localparam logic [IR_WIDTH-1:0] IR_CAPTURE = IR_WIDTH'(2'b01);

  tap_state_e          r_state;
  logic                r_tdo_en;
  logic [IR_WIDTH-1:0] r_ir;
  logic [IR_WIDTH-1:0] r_ir_sr;
  logic [31:0]         r_id_sr;
  logic [DR_WIDTH-1:0] r_user_sr;
  logic                r_byp_sr;
  logic [DR_WIDTH-1:0] r_upd_data;
  logic                r_upd_valid;

  tap_state_e w_next;
  logic       w_sel_id;
  logic       w_sel_user;
  logic       w_dr_lsb;
  logic       w_tdo;

  function automatic tap_state_e f_next(input tap_state_e s, input logic m);
    case (s)
      TLR:      f_next = m ? TLR      : RTI;
      RTI:      f_next = m ? SEL_DR   : RTI;
      SEL_DR:   f_next = m ? SEL_IR   : CAP_DR;
      CAP_DR:   f_next = m ? EXIT1_DR : SHIFT_DR;
      SHIFT_DR: f_next = m ? EXIT1_DR : SHIFT_DR;
      EXIT1_DR: f_next = m ? UPD_DR   : PAUSE_DR;
      PAUSE_DR: f_next = m ? EXIT2_DR : PAUSE_DR;
      EXIT2_DR: f_next = m ? UPD_DR   : SHIFT_DR;
      UPD_DR:   f_next = m ? SEL_DR   : RTI;
      SEL_IR:   f_next = m ? TLR      : CAP_IR;
      CAP_IR:   f_next = m ? EXIT1_IR : SHIFT_IR;
      SHIFT_IR: f_next = m ? EXIT1_IR : SHIFT_IR;
      EXIT1_IR: f_next = m ? UPD_IR   : PAUSE_IR;
      PAUSE_IR: f_next = m ? EXIT2_IR : PAUSE_IR;
      EXIT2_IR: f_next = m ? UPD_IR   : SHIFT_IR;
      UPD_IR:   f_next = m ? SEL_DR   : RTI;
      default:  f_next = TLR;
    endcase
  endfunction

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    w_next     = f_next(r_state, tms);
    w_sel_id   = (r_ir == IDCODE_IR);
    w_sel_user = !w_sel_id && (r_ir == USER_IR);
    w_dr_lsb   = w_sel_id ? r_id_sr[0] : (w_sel_user ? r_user_sr[0] : r_byp_sr);
    w_tdo      = 1'b0;
    if (r_state == SHIFT_IR)      w_tdo = r_ir_sr[0];
    else if (r_state == SHIFT_DR) w_tdo = w_dr_lsb;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= TLR;
      r_tdo_en    <= 1'b0;
      r_ir        <= IDCODE_IR;
      r_ir_sr     <= '0;
      r_id_sr     <= '0;
      r_user_sr   <= '0;
      r_byp_sr    <= 1'b0;
      r_upd_data  <= '0;
      r_upd_valid <= 1'b0;
    end else begin
      r_upd_valid <= 1'b0;
      if (tck_en) begin
        r_state  <= w_next;
        r_tdo_en <= (w_next == SHIFT_DR) || (w_next == SHIFT_IR);
        case (r_state)
          TLR:      r_ir    <= IDCODE_IR;
          CAP_IR:   r_ir_sr <= IR_CAPTURE;
          SHIFT_IR: r_ir_sr <= {tdi, r_ir_sr[IR_WIDTH-1:1]};
          UPD_IR:   r_ir    <= r_ir_sr;
          CAP_DR: begin
            if (w_sel_id)        r_id_sr   <= IDCODE_VAL;
            else if (w_sel_user) r_user_sr <= user_cap_data;
            else                 r_byp_sr  <= 1'b0;
          end
          SHIFT_DR: begin
            if (w_sel_id)        r_id_sr   <= {tdi, r_id_sr[31:1]};
            else if (w_sel_user) r_user_sr <= (r_user_sr >> 1) | (DR_WIDTH'(tdi) << (DR_WIDTH - 1));
            else                 r_byp_sr  <= tdi;
          end
          UPD_DR: begin
            if (w_sel_user) begin
              r_upd_data  <= r_user_sr;
              r_upd_valid <= 1'b1;
            end
          end
          default: ;
        endcase
        // Entering TLR from SEL_IR must expose IDCODE immediately, not one strobe later.
        if (w_next == TLR) r_ir <= IDCODE_IR;
      end
    end
  end

  assign tap_state      = r_state;
  assign tdo_en         = r_tdo_en;
  assign tdo            = r_tdo_en & w_tdo;
  assign ir_out         = r_ir;
  assign user_upd_data  = r_upd_data;
  assign user_upd_valid = r_upd_valid;

endmodule
